canvas_reader: RTL and testbench
================================

Name: canvas_reader

Overview:
- Reads out the 28x28 one-bit drawing canvas as a row-major pixel stream for the neural-network input layer.
- Sits between the canvas pixel memory, through its synchronous read port, and the inference front end.
- Transfers pixels over a valid/ready handshake and reports the number of set pixels at the end of each frame.

Parameters:
- GRID_SIZE, 28: cells per row and per column.
- NUM_PIX, 784: GRID_SIZE*GRID_SIZE; pixels per frame.
- ADDR_W, 10: width of the memory address and of the pixel index.
- PIX_W, 8: width of the output pixel.
- PIX_ON, 8'd255: output value for a set cell. A clear cell outputs 0.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to read one full frame.
- mem_rd  output  1  read strobe to the canvas memory.
- mem_addr  output  ADDR_W  read address, equal to y*GRID_SIZE+x.
- mem_data  input  1  canvas bit; valid exactly 1 cycle after mem_rd.
- pix_data  output  PIX_W  PIX_ON or 0.
- pix_valid  output  1  pix_data, pix_index and pix_last are valid.
- pix_ready  input  1  consumer accepts the pixel this cycle.
- pix_index  output  ADDR_W  index of the current pixel, 0..783.
- pix_last  output  1  high together with index 783.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the frame is complete.
- set_count  output  ADDR_W  number of set pixels in the last frame.

Behaviour:
- Reset (async, resetn=0):
  - All outputs go to 0: mem_rd, mem_addr, pix_*, busy, done, set_count.
  - State goes to IDLE and the buffer is emptied.
  - Reset mid-frame abandons the frame; no done pulse is produced.
- FSM states IDLE -> READ -> DRAIN -> IDLE.
  - IDLE: when start=1, go to READ, set busy=1, clear set_count and the read counters. done stays 0.
  - READ: issue reads. After the read of address NUM_PIX-1 is issued, go to DRAIN.
  - DRAIN: wait for the buffer to empty and the final handshake. Then pulse done=1 for 1 cycle, set busy=0 and return to IDLE.
- start while busy is ignored, with no restart and no corruption of the frame in progress.
- Address generation:
  - Use x/y counters with carry (x wraps at GRID_SIZE-1 and increments y); no multiplier.
  - mem_addr = y*GRID_SIZE+x, held by an incrementing linear counter kept in lockstep with x/y.
- Buffering:
  - Output register plus a 1-entry skid buffer.
  - Occupancy = entries held + read in flight (0 or 1).
  - mem_rd=1 only if in READ and (occupancy - pop_this_cycle) < 2, where pop = pix_valid & pix_ready.
  - No returned data may ever be dropped or duplicated.
- Latency and throughput:
  - With start at cycle 0, mem_rd is first high at cycle 1, mem_data is valid at cycle 2, and pix_valid is first high at cycle 3.
  - With pix_ready held at 1, one pixel transfers per cycle: 784 consecutive transfers, then done 1 cycle after the last transfer.
- Handshake:
  - While pix_valid=1 and pix_ready=0, pix_data, pix_index and pix_last hold stable.
  - pix_valid never drops without a transfer.
- set_count:
  - Increments on every transferred pixel whose value is PIX_ON.
  - It is final and stable from the done pulse until the next accepted start.
- Ordering: pix_index increments by 1 per transfer starting at 0. pix_last=1 only at index NUM_PIX-1.
- Widths: all counters are ADDR_W bits. 784 fits in 10 bits, so no wrap occurs within a frame.

Test Plan:
- All-zero canvas, pix_ready=1, start pulse: 784 pixels all 0, first pix_valid at cycle 3, pix_last at index 783, done 1 cycle after the last transfer, set_count=0.
- Only cell (x=14,y=14) set: exactly index 406 carries 8'd255 and all others carry 0; set_count=1.
- All cells set, pix_ready toggling pseudo-randomly (about 50%): 784 transfers, none lost or repeated, outputs stable while stalled, set_count=784.
- start pulsed again at transfer 100 and at transfer 500: ignored; a single done pulse at the end of the frame and the indices continue uninterrupted.
- resetn asserted at transfer 300: all outputs 0 immediately, no done. A following start produces a clean frame from index 0.
- pix_ready=0 for 50 cycles right after start: pix_valid=1 with index 0 held; at most 2 reads issued in total; the stream resumes correctly when ready returns.

Source files
------------

// File: rtl/canvas_reader_if.sv
// Pixel stream interface between canvas_reader and the inference front end.
//   pix_data  : PIX_ON for a set cell, 0 for a clear cell
//   pix_valid : pix_data, pix_index and pix_last are valid
//   pix_ready : consumer accepts the pixel this cycle
//   pix_index : row-major index of the current pixel
//   pix_last  : high together with the final index of the frame
// The master modport is the producer (canvas_reader); slave is the consumer.
interface canvas_reader_if #(
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 8
);
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_index;
    logic              pix_last;

    modport master (
        output pix_data, pix_valid, pix_index, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_index, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/canvas_reader.sv
// canvas_reader: streams the GRID_SIZE x GRID_SIZE one-bit canvas out in
// row-major order as PIX_W-bit pixels, and counts the set pixels per frame.
//   CLOCK_50  : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   start     : one-cycle request to read a frame (ignored while busy)
//   mem_rd    : read strobe to the canvas memory
//   mem_addr  : read address y*GRID_SIZE+x
//   mem_data  : canvas bit, valid one cycle after mem_rd
//   pix       : pixel stream (canvas_reader_if master)
//   busy      : frame in progress
//   done      : one-cycle pulse after the last pixel transfer
//   set_count : number of set pixels transferred in the last frame
module canvas_reader #(
    parameter int               GRID_SIZE = 28,
    parameter int               NUM_PIX   = GRID_SIZE * GRID_SIZE,
    parameter int               ADDR_W    = 10,
    parameter int               PIX_W     = 8,
    parameter logic [PIX_W-1:0] PIX_ON    = 8'd255
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_data,
    canvas_reader_if.master      pix,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    set_count
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] x, y, addr;
    logic              rd_q;         // a read issued last cycle returns data now
    logic              out_valid, out_bit;
    logic              skid_valid, skid_bit;
    logic [ADDR_W-1:0] xfer_idx;
    logic [1:0]        occ;
    logic              pop, last_read, last_pix, start_ok;

    assign pop       = out_valid & pix.pix_ready;
    assign last_pix  = out_valid && (xfer_idx == ADDR_W'(NUM_PIX - 1));
    assign last_read = (x == ADDR_W'(GRID_SIZE - 1)) && (y == ADDR_W'(GRID_SIZE - 1));
    assign start_ok  = (state == IDLE) && start;

    // Occupancy counts every slot a pixel may land in: output register,
    // skid register and a read still in flight. Keeping (occ - pop) below 2
    // before issuing guarantees a returning bit always has a free register.
    assign occ = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_q};

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                if ((occ - 2'(pop)) < 2'd2) begin
                    mem_rd = 1'b1;
                    if (last_read) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_pix) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples the values from before this clock edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // x/y counters with carry and a linear address kept in lockstep, so the
    // address y*GRID_SIZE+x never needs a multiplier.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (start_ok) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (mem_rd && !last_read) begin
            addr <= addr + 1'b1;
            if (x == ADDR_W'(GRID_SIZE - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Output register plus skid register; data always arrives in order and
    // the skid entry is older than any bit still in flight.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_q       <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            skid_valid <= 1'b0;
            skid_bit   <= 1'b0;
        end else begin
            rd_q <= mem_rd;
            if (pop) begin
                if (skid_valid) begin
                    out_bit    <= skid_bit;
                    skid_valid <= 1'b0;
                end else if (rd_q) begin
                    out_bit <= mem_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_q) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_bit   <= mem_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_bit   <= mem_data;
                end
            end
        end
    end

    // Transfer index, set-pixel count and the end-of-frame pulse.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            xfer_idx  <= '0;
            set_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && pop && last_pix;
            if (start_ok) begin
                xfer_idx  <= '0;
                set_count <= '0;
            end else if (pop) begin
                xfer_idx <= last_pix ? '0 : xfer_idx + 1'b1;
                if (out_bit) set_count <= set_count + 1'b1;
            end
        end
    end

    assign mem_addr      = addr;
    assign busy          = (state != IDLE);
    assign pix.pix_valid = out_valid;
    assign pix.pix_data  = (out_valid && out_bit) ? PIX_ON : '0;
    assign pix.pix_index = xfer_idx;
    assign pix.pix_last  = last_pix;

endmodule

// File: tb/tb_canvas_reader.sv
// Self-checking bench for canvas_reader: a canvas memory model, a per-cycle
// stream monitor compared against an expected row-major pixel sequence, and
// directed frames with randomized canvases and consumer back-pressure.
module tb_canvas_reader;

    localparam int GRID    = 28;
    localparam int NUM_PIX = GRID * GRID;
    localparam int ADDR_W  = 10;
    localparam int PIX_W   = 8;
    localparam int BUDGET  = 6000;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              start = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data = 1'b0;
    logic              busy, done;
    logic [ADDR_W-1:0] set_count;

    canvas_reader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) pix_if ();

    canvas_reader dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .pix       (pix_if.master),
        .busy      (busy),
        .done      (done),
        .set_count (set_count)
    );

    always #5 clk = ~clk;

    bit canvas [NUM_PIX];

    // Synchronous-read canvas memory.
    always @(posedge clk) begin
        if (mem_rd && int'(mem_addr) < NUM_PIX) mem_data <= canvas[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int idx);
        if (idx >= 0 && idx < NUM_PIX && canvas[idx]) return 8'd255;
        return 8'd0;
    endfunction

    function automatic int count_set();
        int n = 0;
        for (int i = 0; i < NUM_PIX; i++) n += int'(canvas[i]);
        return n;
    endfunction

    // Model state for the current frame.
    int         exp_idx, reads, pops, exp_set, done_count;
    int         last_xfer_cyc, first_valid_cyc, first_rd_cyc, start_cyc;
    logic [7:0] val406;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [9:0] prev_index;
    logic       prev_last;

    task automatic frame_begin();
        exp_idx = 0; reads = 0; pops = 0; exp_set = 0; done_count = 0;
        last_xfer_cyc = -1; first_valid_cyc = -1; first_rd_cyc = -1;
        val406 = 8'hxx; prev_stall = 1'b0;
    endtask

    // Per-cycle compare against the expected stream, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_rd) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check("mem_addr", 32'(mem_addr), 32'(reads));
                reads++;
            end
            if (pix_if.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 32'(pix_if.pix_valid), 32'd1);
                check("stall_data",  32'(pix_if.pix_data),  32'(prev_data));
                check("stall_index", 32'(pix_if.pix_index), 32'(prev_index));
                check("stall_last",  32'(pix_if.pix_last),  32'(prev_last));
            end
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                check("pix_index", 32'(pix_if.pix_index), 32'(exp_idx));
                check("pix_data",  32'(pix_if.pix_data),  32'(exp_pix(exp_idx)));
                check("pix_last",  32'(pix_if.pix_last),  32'(exp_idx == NUM_PIX - 1));
                check("busy_xfer", 32'(busy), 32'd1);
                if (exp_idx == 406) val406 = pix_if.pix_data;
                if (exp_pix(exp_idx) != 8'd0) exp_set++;
                if (exp_idx == NUM_PIX - 1) last_xfer_cyc = cyc;
                exp_idx++;
                pops++;
            end
            check("outstanding", 32'(reads - pops <= 2), 32'd1);
            check("done_timing", 32'(done), 32'(last_xfer_cyc >= 0 && cyc == last_xfer_cyc + 1));
            if (done) begin
                done_count++;
                check("set_count_done", 32'(set_count), 32'(exp_set));
            end
            prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
            prev_data  = pix_if.pix_data;
            prev_index = pix_if.pix_index;
            prev_last  = pix_if.pix_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd"},    32'(mem_rd), 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_pix_data"},  32'(pix_if.pix_data), 32'd0);
        check({tag, "_pix_valid"}, 32'(pix_if.pix_valid), 32'd0);
        check({tag, "_pix_index"}, 32'(pix_if.pix_index), 32'd0);
        check({tag, "_pix_last"},  32'(pix_if.pix_last), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_set_count"}, 32'(set_count), 32'd0);
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low for 50 cycles.
    task automatic run_frame(input int rmode, input bit inject, input int rst_at);
        bit fin = 1'b0;
        bit inj100 = 1'b0;
        bit inj500 = 1'b0;
        int c = 0;
        logic [9:0] sc;
        pix_if.pix_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        frame_begin();
        start = 1'b1;
        start_cyc = cyc;
        while (!fin) begin
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (rmode == 1) pix_if.pix_ready = 1'($urandom_range(0, 1));
            if (rmode == 2 && c == 50) begin
                check("stall_reads_max2", 32'(reads <= 2), 32'd1);
                check("stall_valid_held", 32'(pix_if.pix_valid), 32'd1);
                check("stall_index0", 32'(pix_if.pix_index), 32'd0);
                pix_if.pix_ready = 1'b1;
            end
            if (inject && !inj100 && pops == 100) begin start = 1'b1; inj100 = 1'b1; end
            if (inject && !inj500 && pops == 500) begin start = 1'b1; inj500 = 1'b1; end
            if (rst_at >= 0 && pops == rst_at) begin
                resetn = 1'b0;
                #1;
                check_all_zero("rst_mid");
                repeat (5) begin
                    @(posedge clk); #1;
                    check("rst_no_done", 32'(done), 32'd0);
                end
                resetn = 1'b1;
                @(posedge clk); #1;
                check("after_rst_done", 32'(done), 32'd0);
                check("after_rst_busy", 32'(busy), 32'd0);
                return;
            end
            if (done_count > 0) fin = 1'b1;
            if (c > BUDGET) begin
                check("frame_timeout", 32'd0, 32'd1);
                fin = 1'b1;
            end
        end
        check("post_busy", 32'(busy), 32'd0);
        check("post_pops", 32'(pops), 32'(NUM_PIX));
        check("post_set_count", 32'(set_count), 32'(count_set()));
        sc = set_count;
        repeat (3) @(posedge clk);
        #1;
        check("set_count_stable", 32'(set_count), 32'(sc));
        check("single_done", 32'(done_count), 32'd1);
    endtask

    initial begin
        pix_if.pix_ready = 1'b1;
        frame_begin();
        #2 resetn = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // All-zero canvas, consumer always ready.
        for (int i = 0; i < NUM_PIX; i++) canvas[i] = 1'b0;
        run_frame(0, 1'b0, -1);
        check("t1_first_rd", 32'(first_rd_cyc - start_cyc), 32'd1);
        check("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("t1_set_count", 32'(set_count), 32'd0);

        // Single cell (14,14) set.
        canvas[14 * GRID + 14] = 1'b1;
        run_frame(0, 1'b0, -1);
        check("t2_index406", 32'(val406), 32'd255);
        check("t2_set_count", 32'(set_count), 32'd1);

        // All cells set, random back-pressure.
        for (int i = 0; i < NUM_PIX; i++) canvas[i] = 1'b1;
        run_frame(1, 1'b0, -1);
        check("t3_set_count", 32'(set_count), 32'd784);

        // Random canvas, start pulses mid-frame must be ignored.
        for (int i = 0; i < NUM_PIX; i++) canvas[i] = 1'($urandom_range(0, 1));
        run_frame(0, 1'b1, -1);

        // Reset at transfer 300, then a clean frame.
        run_frame(1, 1'b0, 300);
        for (int i = 0; i < NUM_PIX; i++) canvas[i] = 1'($urandom_range(0, 1));
        run_frame(1, 1'b0, -1);

        // Consumer stalled for 50 cycles right after start.
        run_frame(2, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
